// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer.
// State encodings double as the phase code driven to the packet compiler.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SYNC      = 3'd1,
      ST_PID       = 3'd2,
      ST_DATA      = 3'd3,
      ST_CRC       = 3'd4,
      ST_EOP       = 3'd5,
      ST_WAIT_DONE = 3'd6,
      ST_ERROR     = 3'd7
   } tx_state_t;

   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam logic [2:0] REQ_NONE  = 3'd0;
   localparam logic [2:0] REQ_DATA0 = 3'd1;
   localparam logic [2:0] REQ_DATA1 = 3'd2;
   localparam logic [2:0] REQ_ACK   = 3'd3;
   localparam logic [2:0] REQ_NAK   = 3'd4;
   localparam logic [2:0] REQ_STALL = 3'd5;

   localparam int unsigned MAX_DATA_BYTES_DEF = 32'd64;

   function automatic logic [3:0] pid_of(input logic [2:0] req);
      logic [3:0] pid;
      case (req)
         REQ_DATA0: pid = PID_DATA0;
         REQ_DATA1: pid = PID_DATA1;
         REQ_ACK:   pid = PID_ACK;
         REQ_NAK:   pid = PID_NAK;
         REQ_STALL: pid = PID_STALL;
         default:   pid = 4'b0000;
      endcase
      return pid;
   endfunction

   function automatic logic is_data_req(input logic [2:0] req);
      return (req == REQ_DATA0) || (req == REQ_DATA1);
   endfunction

endpackage

// File: rtl/usb_tx_watchdog.sv
// Packet watchdog: counts enabled cycles and emits a single timeout pulse
// once TIMEOUT_CYCLES enabled cycles have been seen since the last clear.
module usb_tx_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd4800
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 32'd1);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [CW-1:0] count_r;
   logic          timeout_r;

   // Saturating counter so the timeout fires exactly once per packet
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_r   <= '0;
         timeout_r <= 1'b0;
      end else if (clear) begin
         count_r   <= '0;
         timeout_r <= 1'b0;
      end else if (enable) begin
         count_r   <= (count_r == LIMIT) ? count_r : count_r + ONE;
         timeout_r <= (count_r == LAST);
      end else begin
         count_r   <= count_r;
         timeout_r <= 1'b0;
      end
   end

   assign timeout = timeout_r;

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit control FSM: accepts a request, walks the compiler phases and
// launches the serializer. Optional watchdog under USB_TX_SEQ_WATCHDOG_EN.
module usb_tx_sequencer
   import usb_tx_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32'd4800,
   parameter int unsigned MAX_DATA_BYTES = MAX_DATA_BYTES_DEF
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] TX_Packet,
   input  logic [6:0] Buffer_Occupancy,
   input  logic       packet_load_complete_TX,
   input  logic       tx_done,
   output logic [2:0] c_state_TX,
   output logic [3:0] pID,
   output logic       tx_ack,
   output logic       start_shift,
   output logic       TX_Transfer_Active,
   output logic       TX_Error
);

   tx_state_t  state_r, base_state_s, state_s;
   logic       hs_r, hs_s, zlp_r, zlp_s;
   logic [3:0] pid_r, pid_base_s, pid_s;
   logic       ack_r, ack_s, start_r, base_start_s, start_s;
   logic       active_r, active_base_s, active_s, err_r, err_s;
   logic       req_legal_s, req_data_s, oversize_s, wdog_fire_s;

   assign req_legal_s = TX_Packet inside {[REQ_DATA0:REQ_STALL]};
   assign req_data_s  = is_data_req(TX_Packet);
   assign oversize_s  = 32'(Buffer_Occupancy) > MAX_DATA_BYTES;

   // Next-state and next-output decode
   always_comb begin
      base_state_s  = state_r;
      hs_s          = hs_r;
      zlp_s         = zlp_r;
      pid_base_s    = pid_r;
      active_base_s = active_r;
      ack_s         = 1'b0;
      base_start_s  = 1'b0;
      err_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_legal_s) begin
               ack_s         = 1'b1;
               active_base_s = 1'b1;
               pid_base_s    = pid_of(TX_Packet);
               hs_s          = ~req_data_s;
               zlp_s         = (Buffer_Occupancy == 7'd0);
               base_state_s  = (req_data_s && oversize_s) ? ST_ERROR : ST_SYNC;
            end else if (TX_Packet != REQ_NONE) begin
               base_state_s = ST_ERROR;
            end else begin
               base_state_s = ST_IDLE;
            end
         end
         ST_SYNC: base_state_s = ST_PID;
         ST_PID: begin
            if (hs_r) begin
               base_state_s = ST_EOP;
            end else if (zlp_r) begin
               base_state_s = ST_CRC;
            end else begin
               base_state_s = ST_DATA;
            end
         end
         ST_DATA: base_state_s = packet_load_complete_TX ? ST_CRC : ST_DATA;
         ST_CRC:  base_state_s = ST_EOP;
         ST_EOP: begin
            base_start_s = 1'b1;
            base_state_s = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: base_state_s = tx_done ? ST_IDLE : ST_WAIT_DONE;
         ST_ERROR: begin
            err_s        = 1'b1;
            base_state_s = ST_IDLE;
         end
         default: base_state_s = ST_IDLE;
      endcase
   end

   // A watchdog expiry overrides whatever the phase logic wanted
   assign state_s  = wdog_fire_s ? ST_ERROR : base_state_s;
   assign start_s  = base_start_s & ~wdog_fire_s;
   assign active_s = (state_s == ST_IDLE) ? 1'b0 : active_base_s;
   assign pid_s    = (state_s == ST_IDLE) ? 4'b0000 : pid_base_s;

   // State and output registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r  <= ST_IDLE;
         hs_r     <= 1'b0;
         zlp_r    <= 1'b0;
         pid_r    <= 4'b0000;
         ack_r    <= 1'b0;
         start_r  <= 1'b0;
         active_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         hs_r     <= hs_s;
         zlp_r    <= zlp_s;
         pid_r    <= pid_s;
         ack_r    <= ack_s;
         start_r  <= start_s;
         active_r <= active_s;
         err_r    <= err_s;
      end
   end

`ifdef USB_TX_SEQ_WATCHDOG_EN
   logic wdog_clear_s, wdog_en_s, wdog_timeout_s;

   assign wdog_clear_s = (state_r == ST_IDLE);
   assign wdog_en_s    = (state_r != ST_IDLE) && (state_r != ST_ERROR);
   assign wdog_fire_s  = wdog_timeout_s && wdog_en_s;

   usb_tx_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (wdog_clear_s),
      .enable  (wdog_en_s),
      .timeout (wdog_timeout_s)
   );
`else
   logic [31:0] unused_timeout_s;
   assign unused_timeout_s = TIMEOUT_CYCLES;
   assign wdog_fire_s      = 1'b0;
`endif

   assign c_state_TX         = state_r;
   assign pID                = pid_r;
   assign tx_ack             = ack_r;
   assign start_shift        = start_r;
   assign TX_Transfer_Active = active_r;
   assign TX_Error           = err_r;

endmodule
